random_nibble_gen: RTL
======================

# random_nibble_gen

Pseudo-random source that feeds the rope speed generator. A free-running 32-bit Galois LFSR is sampled on request into a bank of NUMBERS 4-bit values. The bank is presented as one coherent, registered set, so the downstream speed stage never sees a partially updated bank. The bank is refreshed on demand or, optionally, once per video frame.

## Interface
- NUMBERS, 9, number of 4-bit values in the output bank (1..16)
- SEED, 32'hACE1_1234, reset value of the LFSR; must be nonzero
- TAPS, 32'h8020_0003, Galois feedback mask (x^32+x^22+x^2+x+1)
- clk  in  1  system clock; all state updates on the rising edge
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle frame strobe from the VGA controller
- request  in  1  level; asks for a new bank
- reseed  in  1  one-cycle strobe that loads seed_in into the LFSR
- seed_in  in  32  new LFSR state
- randomnumbers  out  [NUMBERS-1:0][3:0]  current bank
- valid  out  1  high once any bank has completed since reset
- busy  out  1  high while a bank is being filled
- done  out  1  one-cycle pulse when a new bank lands

## Operation
- Reset values: lfsr=SEED, state=IDLE, index=0, shadow=0, randomnumbers all 0, valid=0, busy=0, done=0.
- LFSR stepping:
  - The LFSR steps on every clock edge not overridden by reseed, in all states.
  - Step rule: if lfsr[0], lfsr <= (lfsr>>1)^TAPS; else lfsr <= lfsr>>1.
- Reseed:
  - lfsr <= seed_in if seed_in!=0, else lfsr <= SEED. The LFSR never holds zero.
  - Reseed has priority over stepping and over request/trigger in that cycle.
  - Reseed during FILL aborts the fill: state goes to IDLE and index is cleared. randomnumbers and valid are unchanged, and done does not pulse.
- FSM states: IDLE, FILL.
  - IDLE: trigger = request (plus startOfFrame, see Configuration). If trigger is high and reseed is low, go to FILL with index=0.
  - FILL: on each edge, shadow[index] <= lfsr[3:0] (the pre-step value) and index increments.
  - When index==NUMBERS-1: randomnumbers <= shadow, with slot NUMBERS-1 taking the nibble captured at that same edge. At that edge valid <= 1, done <= 1 for one cycle, and state returns to IDLE.
- Triggers arriving while in FILL are ignored and not queued. A trigger in the cycle FILL completes is also ignored.
- A held request restarts a fill on the edge after completion, so back-to-back banks are produced every NUMBERS+1 cycles.
- index is $clog2(NUMBERS)-bit wide (minimum 1); it never exceeds NUMBERS-1.
- valid is sticky and is cleared only by resetN.
- busy is combinational: (state==FILL).

## Timing
- Trigger is sampled at edge t (IDLE) and busy rises after edge t.
- Nibbles are captured at edges t+1 .. t+NUMBERS.
- The new bank, done and valid are visible after edge t+NUMBERS, giving a latency of NUMBERS cycles. busy falls after the same edge.
- randomnumbers changes only on a done edge, with all slots updating simultaneously.
- Asserting resetN low at any time immediately forces all reset values, including mid-FILL.

## Configuration
- RANDOM_AUTO_REFRESH_EN defined: trigger = request | startOfFrame. A bank is refilled once per frame without the consumer asserting request.
- Undefined: trigger = request only. startOfFrame is ignored and may be tied low.

## Test plan
- Reset: hold resetN low, then release. Required: all outputs are 0. After 20 idle cycles, valid is still 0 and randomnumbers is still 0.
- Latency with NUMBERS=9:
  - Stimulus: pulse request at edge t.
  - busy is high for 9 cycles, and done pulses after edge t+9. valid=1 from then on.
  - No randomnumbers slot changes before edge t+9.
- Deterministic values:
  - Stimulus: reseed with seed_in=32'h1 at edge e, then request sampled at edge e+1.
  - Required: randomnumbers[0]=3, [1]=2, [2]=1.
  - Zero seed: a reseed with seed_in=0 loads 32'hACE1_1234.
- Abort: pulse reseed 4 cycles into a fill. Required: busy drops, done never pulses, and randomnumbers and valid keep their prior values.
- Held request: hold request high for 30 cycles. Required: done pulses every 10 cycles and request is ignored while busy. Over 10^5 cycles the LFSR never reads 0.
- Auto refresh:
  - With RANDOM_AUTO_REFRESH_EN, a startOfFrame pulse alone produces done 9 cycles later.
  - Without the macro, the same stimulus produces no done pulse and busy stays 0.

Source files
------------

// File: rtl/random_nibble_gen.sv
// ============================================================================
// random_nibble_gen
// ----------------------------------------------------------------------------
// Pseudo-random nibble source for the rope speed generator.
//
// A free-running 32-bit Galois LFSR steps on every clock. On a trigger the
// block walks through NUMBERS cycles. Each cycle it samples the low nibble of
// the LFSR into a shadow bank. When the last slot is captured, the whole
// shadow bank is copied into the registered output bank in a single edge.
// Because of that copy, the speed stage never observes a half-written bank.
//
// Optional feature (compile-time macro):
//   RANDOM_AUTO_REFRESH_EN  defined   -> trigger = request | startOfFrame
//                           undefined -> trigger = request (startOfFrame unused)
//
// Parameters:
//   NUMBERS  number of 4-bit values in the bank (1..16)
//   SEED     LFSR reset value and fallback reseed value (nonzero)
//   TAPS     Galois feedback mask
//
// Ports:
//   clk            in   system clock, rising-edge
//   resetN         in   asynchronous active-low reset
//   startOfFrame   in   one-cycle frame strobe from the VGA controller
//   request        in   level request for a new bank
//   reseed         in   one-cycle strobe, loads seed_in into the LFSR
//   seed_in        in   [31:0] new LFSR state (zero selects SEED instead)
//   randomnumbers  out  [NUMBERS-1:0][3:0] current coherent bank
//   valid          out  sticky, high once any bank has completed
//   busy           out  high while a bank is being filled
//   done           out  one-cycle pulse when a new bank lands
// ============================================================================
module random_nibble_gen #(
    parameter int unsigned NUMBERS = 9,
    parameter logic [31:0] SEED    = 32'hACE1_1234,
    parameter logic [31:0] TAPS    = 32'h8020_0003
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    request,
    input  logic                    reseed,
    input  logic [31:0]             seed_in,
    output logic [NUMBERS-1:0][3:0] randomnumbers,
    output logic                    valid,
    output logic                    busy,
    output logic                    done
);

    // A single-slot bank still needs a 1-bit index.
    localparam int unsigned    IDX_W    = (NUMBERS > 1) ? $clog2(NUMBERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBERS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    logic [31:0]              lfsr_q,   lfsr_d;
    state_t                   state_q,  state_d;
    logic [IDX_W-1:0]         index_q,  index_d;
    logic [NUMBERS-1:0][3:0]  shadow_q, shadow_d;
    logic [NUMBERS-1:0][3:0]  bank_q,   bank_d;
    logic                     valid_q,  valid_d;
    logic                     done_q,   done_d;

    logic [31:0]              lfsr_step;
    logic                     trigger;

    // ------------------------------------------------------------------------
    // Trigger selection
    // ------------------------------------------------------------------------
`ifdef RANDOM_AUTO_REFRESH_EN
    // Refill once per video frame even if the consumer never asks.
    assign trigger = request | startOfFrame;
`else
    // Frame strobe is not used in this build.
    assign trigger = request;
    logic unused_start_of_frame;
    assign unused_start_of_frame = startOfFrame;
`endif

    // ------------------------------------------------------------------------
    // LFSR next state
    // ------------------------------------------------------------------------
    // Galois step: shift right, fold the taps in when the bit shifted out
    // is 1. A nonzero state never steps to zero, so the only way to reach
    // zero would be a zero reseed. That case is mapped back to SEED.
    always_comb begin
        lfsr_step = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_step = (lfsr_q >> 1) ^ TAPS;
        end

        lfsr_d = lfsr_step;
        if (reseed) begin
            lfsr_d = (seed_in != 32'h0) ? seed_in : SEED;
        end
    end

    // ------------------------------------------------------------------------
    // Fill FSM, shadow bank and output bank
    // ------------------------------------------------------------------------
    // IDLE waits for a trigger. FILL captures the pre-step LFSR nibble into
    // shadow[index] on every edge. On the last slot, the new shadow contents
    // (including the nibble captured on that same edge) are copied to the
    // output bank in one step. A reseed takes priority over everything. In
    // FILL it abandons the partial bank without touching the output bank.
    // Triggers seen while in FILL are dropped, not queued.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        shadow_d = shadow_q;
        bank_d   = bank_q;
        valid_d  = valid_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (trigger && !reseed) begin
                    state_d = FILL;
                    index_d = '0;
                end
            end

            FILL: begin
                if (reseed) begin
                    state_d = IDLE;
                    index_d = '0;
                end else begin
                    shadow_d[index_q] = lfsr_q[3:0];
                    if (index_q == LAST_IDX) begin
                        bank_d  = shadow_d;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                        index_d = '0;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                index_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Register update. Reset is asynchronous, so pulling resetN low mid-fill
    // clears everything at once.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lfsr_q   <= SEED;
            state_q  <= IDLE;
            index_q  <= '0;
            shadow_q <= '0;
            bank_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            state_q  <= state_d;
            index_q  <= index_d;
            shadow_q <= shadow_d;
            bank_q   <= bank_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign randomnumbers = bank_q;
    assign valid         = valid_q;
    assign done          = done_q;
    assign busy          = (state_q == FILL);

endmodule
